wb_commit_buffer: RTL and testbench

- Parametrised successor to the single-channel writeback stage.
- Accepts up to NCH writeback results per cycle, each from an issue lane.
- Selects each lane's result source (cp0 > link > mem > ex priority), queues the register writes in program order in a DEPTH-entry circular buffer, and drains them to NWP register-file write ports per cycle.
- Exposes a bypass lookup over pending entries so decode sees not-yet-retired values.

---
 rtl/cpu_defs.sv | 18 +
 rtl/wb_result_sel.sv | 33 +++
 rtl/wb_commit_buffer.sv | 175 +++++++++++++++++
 tb/tb_wb_commit_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared writeback types: result source select, buffered register write, zero register.
package cpu_defs;

    typedef enum logic [1:0] {
        WB_EX,
        WB_MEM,
        WB_LINK,
        WB_CP0
    } wb_src_t;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_result_sel.sv
// Per-lane writeback result mux: cp0 > link > mem > ex, purely combinational.
module wb_result_sel
    import cpu_defs::*;
(
    input  logic        mfc0_i,
    input  logic        link_i,
    input  logic        memtoreg_i,
    input  logic [31:0] ex_out_i,
    input  logic [31:0] rdata_i,
    input  logic [31:0] pcplus8_i,
    input  logic [31:0] cp0_rdata_i,
    output logic [31:0] result_o
);

    wb_src_t src;

    always_comb begin
        if (mfc0_i)          src = WB_CP0;
        else if (link_i)     src = WB_LINK;
        else if (memtoreg_i) src = WB_MEM;
        else                 src = WB_EX;
    end

    always_comb begin
        case (src)
            WB_CP0:  result_o = cp0_rdata_i;
            WB_LINK: result_o = pcplus8_i;
            WB_MEM:  result_o = rdata_i;
            default: result_o = ex_out_i;
        endcase
    end

endmodule

// File: rtl/wb_commit_buffer.sv
// In-order multi-lane writeback queue draining NWP register writes per cycle, with bypass lookup.
// Latency 1 from acceptance to rf_*; in_ready is group-level and counts same-cycle drain; drain never stalls.
module wb_commit_buffer
    import cpu_defs::*;
#(
    parameter int NCH   = 2,
    parameter int NWP   = 1,
    parameter int DEPTH = 4,
    parameter int NQ    = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [NCH-1:0]           in_valid,
    output logic                     in_ready,
    input  logic [NCH-1:0]           in_regwrite,
    input  logic [NCH-1:0]           in_mfc0,
    input  logic [NCH-1:0]           in_link,
    input  logic [NCH-1:0]           in_memtoreg,
    input  logic [NCH*5-1:0]         in_waddr,
    input  logic [NCH*32-1:0]        in_ex_out,
    input  logic [NCH*32-1:0]        in_rdata,
    input  logic [NCH*32-1:0]        in_pcplus8,
    input  logic [NCH*32-1:0]        in_cp0_rdata,
    output logic [NWP-1:0]           rf_we,
    output logic [NWP*5-1:0]         rf_waddr,
    output logic [NWP*32-1:0]        rf_wdata,
    input  logic [NQ*5-1:0]          q_raddr,
    output logic [NQ-1:0]            q_hit,
    output logic [NQ*32-1:0]         q_data,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);
    localparam logic [PW:0] NCH_L   = (PW+1)'(NCH);

    wb_entry_t        entry_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;

    wb_entry_t        lane_ent [NCH];
    logic [NCH-1:0]   lane_qual;

    for (genvar l = 0; l < NCH; l++) begin : g_lane
        logic [31:0] res;
        wb_result_sel u_sel (
            .mfc0_i      (in_mfc0[l]),
            .link_i      (in_link[l]),
            .memtoreg_i  (in_memtoreg[l]),
            .ex_out_i    (in_ex_out[l*32 +: 32]),
            .rdata_i     (in_rdata[l*32 +: 32]),
            .pcplus8_i   (in_pcplus8[l*32 +: 32]),
            .cp0_rdata_i (in_cp0_rdata[l*32 +: 32]),
            .result_o    (res)
        );
        assign lane_ent[l]  = '{waddr: in_waddr[l*5 +: 5], data: res};
        assign lane_qual[l] = in_valid[l] & in_regwrite[l] & (in_waddr[l*5 +: 5] != REG_ZERO);
    end

    // Drain window: the NWP slots starting at head; valids are contiguous from head.
    logic [AW-1:0]  drain_idx [NWP];
    logic [NWP-1:0] drain_v;
    logic [PW-1:0]  deq_cnt;

    always_comb begin
        for (int p = 0; p < NWP; p++) drain_idx[p] = head_q[AW-1:0] + AW'(p);
    end

    always_comb begin
        drain_v = '0;
        deq_cnt = '0;
        for (int p = 0; p < NWP; p++) begin
            drain_v[p] = valid_q[drain_idx[p]];
            deq_cnt    = deq_cnt + PW'(drain_v[p]);
        end
    end

    // Only the youngest of same-address writes in one drain group reaches the file.
    always_comb begin
        rf_we    = '0;
        rf_waddr = '0;
        rf_wdata = '0;
        for (int p = 0; p < NWP; p++) begin
            rf_waddr[p*5 +: 5]  = entry_q[drain_idx[p]].waddr;
            rf_wdata[p*32 +: 32] = entry_q[drain_idx[p]].data;
            rf_we[p]             = drain_v[p];
            for (int y = p + 1; y < NWP; y++) begin
                if (drain_v[y] && (entry_q[drain_idx[y]].waddr == entry_q[drain_idx[p]].waddr))
                    rf_we[p] = 1'b0;
            end
        end
    end

    logic [PW:0] room;

    assign occupancy = tail_q - head_q;
    assign empty     = (occupancy == '0);
    assign room      = DEPTH_L - {1'b0, occupancy} + {1'b0, deq_cnt};
    assign in_ready  = (room >= NCH_L);

    logic             accept;
    logic [PW-1:0]    enq_cnt;
    logic [AW-1:0]    slot_idx;
    logic [DEPTH-1:0] slot_we;
    wb_entry_t        slot_ent [DEPTH];

    assign accept = (|in_valid) & in_ready;

    // Qualifying lanes pack into consecutive slots from tail, wrapping modulo DEPTH.
    always_comb begin
        enq_cnt  = '0;
        slot_idx = '0;
        slot_we  = '0;
        for (int s = 0; s < DEPTH; s++) slot_ent[s] = '0;
        for (int l = 0; l < NCH; l++) begin
            if (accept && lane_qual[l]) begin
                slot_idx           = tail_q[AW-1:0] + enq_cnt[AW-1:0];
                slot_we[slot_idx]  = 1'b1;
                slot_ent[slot_idx] = lane_ent[l];
                enq_cnt            = enq_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        valid_d = valid_q;
        for (int p = 0; p < NWP; p++) begin
            if (drain_v[p]) valid_d[drain_idx[p]] = 1'b0;
        end
        valid_d = valid_d | slot_we;
    end

    assign head_d = head_q + deq_cnt;
    assign tail_d = tail_q + enq_cnt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int s = 0; s < DEPTH; s++) begin
            if (slot_we[s]) entry_q[s] <= slot_ent[s];
        end
    end

    // Scanning oldest to youngest lets the youngest match overwrite earlier ones.
    logic [AW-1:0] byp_idx;

    always_comb begin
        q_hit   = '0;
        q_data  = '0;
        byp_idx = '0;
        for (int q = 0; q < NQ; q++) begin
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = head_q[AW-1:0] + AW'(i);
                if (valid_q[byp_idx] && (q_raddr[q*5 +: 5] != REG_ZERO) &&
                    (entry_q[byp_idx].waddr == q_raddr[q*5 +: 5])) begin
                    q_hit[q]           = 1'b1;
                    q_data[q*32 +: 32] = entry_q[byp_idx].data;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Two configurations (NWP=1 and NWP=2) share one stimulus stream; a queue model predicts writes and lookups.
module tb_wb_commit_buffer;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  in_valid, in_regwrite, in_mfc0, in_link, in_memtoreg;
    logic [9:0]  in_waddr;
    logic [63:0] in_ex_out, in_rdata, in_pcplus8, in_cp0_rdata;
    logic [9:0]  q_raddr;

    logic        ready1, empty1, ready2, empty2;
    logic [0:0]  rf_we1;
    logic [4:0]  rf_waddr1;
    logic [31:0] rf_wdata1;
    logic [1:0]  rf_we2;
    logic [9:0]  rf_waddr2;
    logic [63:0] rf_wdata2;
    logic [1:0]  q_hit1, q_hit2;
    logic [63:0] q_data1, q_data2;
    logic [2:0]  occ1, occ2;

    always #5 clk = ~clk;

    wb_commit_buffer #(.NCH(2), .NWP(1), .DEPTH(4), .NQ(2)) u_dut1 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ready1),
        .in_regwrite(in_regwrite), .in_mfc0(in_mfc0), .in_link(in_link), .in_memtoreg(in_memtoreg),
        .in_waddr(in_waddr), .in_ex_out(in_ex_out), .in_rdata(in_rdata), .in_pcplus8(in_pcplus8),
        .in_cp0_rdata(in_cp0_rdata), .rf_we(rf_we1), .rf_waddr(rf_waddr1), .rf_wdata(rf_wdata1),
        .q_raddr(q_raddr), .q_hit(q_hit1), .q_data(q_data1), .occupancy(occ1), .empty(empty1)
    );

    wb_commit_buffer #(.NCH(2), .NWP(2), .DEPTH(4), .NQ(2)) u_dut2 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(ready2),
        .in_regwrite(in_regwrite), .in_mfc0(in_mfc0), .in_link(in_link), .in_memtoreg(in_memtoreg),
        .in_waddr(in_waddr), .in_ex_out(in_ex_out), .in_rdata(in_rdata), .in_pcplus8(in_pcplus8),
        .in_cp0_rdata(in_cp0_rdata), .rf_we(rf_we2), .rf_waddr(rf_waddr2), .rf_wdata(rf_wdata2),
        .q_raddr(q_raddr), .q_hit(q_hit2), .q_data(q_data2), .occupancy(occ2), .empty(empty2)
    );

    logic [1:0]  we_m  [2];
    logic [4:0]  wa_m  [2][2];
    logic [31:0] wd_m  [2][2];
    logic [1:0]  qh_m  [2];
    logic [31:0] qd_m  [2][2];
    logic [2:0]  occ_m [2];
    logic        emp_m [2];
    logic        rdy_m [2];

    assign we_m[0] = {1'b0, rf_we1};
    assign we_m[1] = rf_we2;
    assign wa_m[0][0] = rf_waddr1;        assign wa_m[0][1] = 5'd0;
    assign wa_m[1][0] = rf_waddr2[4:0];   assign wa_m[1][1] = rf_waddr2[9:5];
    assign wd_m[0][0] = rf_wdata1;        assign wd_m[0][1] = 32'd0;
    assign wd_m[1][0] = rf_wdata2[31:0];  assign wd_m[1][1] = rf_wdata2[63:32];
    assign qh_m[0] = q_hit1;              assign qh_m[1] = q_hit2;
    assign qd_m[0][0] = q_data1[31:0];    assign qd_m[0][1] = q_data1[63:32];
    assign qd_m[1][0] = q_data2[31:0];    assign qd_m[1][1] = q_data2[63:32];
    assign occ_m[0] = occ1;               assign occ_m[1] = occ2;
    assign emp_m[0] = empty1;             assign emp_m[1] = empty2;
    assign rdy_m[0] = ready1;             assign rdy_m[1] = ready2;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: pending writes as a program-order queue per configuration.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t mq   [2][$];
    ent_t expw [2][$];

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic bit ready_rule(input int sz, input int nwp);
        return (4 - sz + min2(sz, nwp)) >= 2;
    endfunction

    function automatic logic [31:0] lane_result(input int l);
        if (in_mfc0[l])          return in_cp0_rdata[l*32 +: 32];
        else if (in_link[l])     return in_pcplus8[l*32 +: 32];
        else if (in_memtoreg[l]) return in_rdata[l*32 +: 32];
        else                     return in_ex_out[l*32 +: 32];
    endfunction

    int   m_sz, m_deq, m_nwp;
    bit   m_acc, m_dup;
    ent_t m_e;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            m_nwp = k + 1;
            m_sz  = mq[k].size();
            m_deq = min2(m_sz, m_nwp);
            if (!resetn) begin
                mq[k].delete();
                expw[k].delete();
            end else begin
                m_acc = (in_valid != 2'b00) && ready_rule(m_sz, m_nwp);
                for (int i = 0; i < m_deq; i++) m_e = mq[k].pop_front();
                if (m_acc) begin
                    for (int l = 0; l < 2; l++) begin
                        if (in_valid[l] && in_regwrite[l] && (in_waddr[l*5 +: 5] != 5'd0)) begin
                            m_e.a = in_waddr[l*5 +: 5];
                            m_e.d = lane_result(l);
                            mq[k].push_back(m_e);
                        end
                    end
                end
                m_deq = min2(mq[k].size(), m_nwp);
                for (int i = 0; i < m_deq; i++) begin
                    m_dup = 1'b0;
                    for (int j = i + 1; j < m_deq; j++)
                        if (mq[k][j].a == mq[k][i].a) m_dup = 1'b1;
                    if (!m_dup) expw[k].push_back(mq[k][i]);
                end
            end
        end
    end

    ent_t        mon_e;
    bit          mon_hit;
    logic [31:0] mon_d;
    logic [4:0]  mon_qa;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("occ%0d", k), 32'(occ_m[k]), 32'(mq[k].size()));
            chk($sformatf("empty%0d", k), 32'(emp_m[k]), 32'(mq[k].size() == 0));
            chk($sformatf("ready%0d", k), 32'(rdy_m[k]), 32'(ready_rule(mq[k].size(), k + 1)));
            for (int p = 0; p <= k; p++) begin
                if (we_m[k][p]) begin
                    if (expw[k].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL wr%0d_extra: port %0d wrote r%0d, expected no write", k, p, wa_m[k][p]);
                    end else begin
                        mon_e = expw[k].pop_front();
                        chk($sformatf("wr%0d_addr_p%0d", k, p), 32'(wa_m[k][p]), 32'(mon_e.a));
                        chk($sformatf("wr%0d_data_p%0d", k, p), wd_m[k][p], mon_e.d);
                    end
                end
            end
            chk($sformatf("wr%0d_missing", k), 32'(expw[k].size()), 32'd0);
            expw[k].delete();
            for (int q = 0; q < 2; q++) begin
                mon_qa  = q_raddr[q*5 +: 5];
                mon_hit = 1'b0;
                mon_d   = 32'd0;
                if (mon_qa != 5'd0) begin
                    for (int i = mq[k].size() - 1; i >= 0; i--) begin
                        if (mq[k][i].a == mon_qa) begin
                            mon_hit = 1'b1;
                            mon_d   = mq[k][i].d;
                            break;
                        end
                    end
                end
                chk($sformatf("qhit%0d_%0d", k, q), 32'(qh_m[k][q]), 32'(mon_hit));
                if (mon_hit) chk($sformatf("qdata%0d_%0d", k, q), qd_m[k][q], mon_d);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_lanes();
        in_valid = '0; in_regwrite = '0; in_mfc0 = '0; in_link = '0; in_memtoreg = '0;
        in_waddr = '0; in_ex_out = '0; in_rdata = '0; in_pcplus8 = '0; in_cp0_rdata = '0;
    endtask

    // src: 0 ex, 1 mem, 2 link, 3 cp0; lower-priority flags are randomised to exercise priority.
    task automatic set_lane(input int l, input int src, input logic [4:0] wa, input logic [31:0] v);
        in_valid[l]    = 1'b1;
        in_regwrite[l] = 1'b1;
        in_waddr[l*5 +: 5] = wa;
        in_ex_out[l*32 +: 32]    = $urandom;
        in_rdata[l*32 +: 32]     = $urandom;
        in_pcplus8[l*32 +: 32]   = $urandom;
        in_cp0_rdata[l*32 +: 32] = $urandom;
        in_mfc0[l]     = (src == 3);
        in_link[l]     = (src == 2) || (src == 3 && $urandom_range(0, 1) == 1);
        in_memtoreg[l] = (src == 1) || (src >= 2 && $urandom_range(0, 1) == 1);
        case (src)
            0: in_ex_out[l*32 +: 32]    = v;
            1: in_rdata[l*32 +: 32]     = v;
            2: in_pcplus8[l*32 +: 32]   = v;
            default: in_cp0_rdata[l*32 +: 32] = v;
        endcase
    endtask

    initial begin
        resetn  = 1'b0;
        q_raddr = '0;
        clear_lanes();
        repeat (2) tick();
        resetn = 1'b1;
        @(negedge clk);
        chk("reset_empty", 32'(empty1), 32'd1);
        chk("reset_ready", 32'(ready1), 32'd1);
        chk("reset_we", 32'(rf_we2), 32'd0);

        // Single write, one-cycle latency.
        tick();
        set_lane(0, 0, 5'd3, 32'h11);
        tick();
        clear_lanes();
        @(negedge clk);
        chk("t1_we", 32'(rf_we1), 32'd1);
        chk("t1_addr", 32'(rf_waddr1), 32'd3);
        chk("t1_data", rf_wdata1, 32'h11);
        tick();
        @(negedge clk);
        chk("t1_empty_after", 32'(empty1), 32'd1);

        // Two lanes, one write port: oldest first.
        tick();
        set_lane(0, 3, 5'd5, 32'hAA);
        set_lane(1, 2, 5'd31, 32'hBFC00008);
        tick();
        clear_lanes();
        @(negedge clk);
        chk("t2_addr0", 32'(rf_waddr1), 32'd5);
        chk("t2_data0", rf_wdata1, 32'hAA);
        tick();
        @(negedge clk);
        chk("t2_addr1", 32'(rf_waddr1), 32'd31);
        chk("t2_data1", rf_wdata1, 32'hBFC00008);

        // Fill until the single-port buffer pushes back, then lane1 to r0.
        repeat (3) tick();
        for (int c = 0; c < 3; c++) begin
            set_lane(0, 0, 5'(10 + c), 32'h100 + 32'(c));
            set_lane(1, 1, 5'(20 + c), 32'h200 + 32'(c));
            tick();
        end
        @(negedge clk);
        chk("t3_full_occ", 32'(occ1), 32'd4);
        chk("t3_full_ready", 32'(ready1), 32'd0);
        for (int c = 0; c < 6; c++) begin
            set_lane(0, 0, 5'(1 + c), 32'h300 + 32'(c));
            set_lane(1, 0, 5'd0, 32'hDEAD);
            tick();
        end
        clear_lanes();
        repeat (8) tick();

        // Bypass returns the youngest pending value.
        set_lane(0, 0, 5'd7, 32'h1);
        set_lane(1, 0, 5'd7, 32'h2);
        q_raddr = {5'd0, 5'd7};
        tick();
        clear_lanes();
        @(negedge clk);
        chk("t4_hit", 32'(q_hit1[0]), 32'd1);
        chk("t4_data", q_data1[31:0], 32'h2);
        chk("t4_r0_nohit", 32'(q_hit1[1]), 32'd0);
        chk("t4_hit_draining", 32'(q_hit2[0]), 32'd1);
        repeat (2) tick();
        @(negedge clk);
        chk("t4_hit_gone", 32'(q_hit1[0]), 32'd0);

        // Same-address pair in one drain group on the two-port buffer.
        repeat (2) tick();
        set_lane(0, 0, 5'd9, 32'h5);
        set_lane(1, 0, 5'd9, 32'h6);
        tick();
        clear_lanes();
        @(negedge clk);
        chk("t5_we", 32'(rf_we2), 32'b10);
        chk("t5_addr1", 32'(rf_waddr2[9:5]), 32'd9);
        chk("t5_data1", rf_wdata2[63:32], 32'h6);

        // Reset with pending entries and a valid input.
        repeat (3) tick();
        set_lane(0, 0, 5'd1, 32'h41);
        set_lane(1, 0, 5'd2, 32'h42);
        tick();
        set_lane(0, 0, 5'd3, 32'h43);
        set_lane(1, 0, 5'd4, 32'h44);
        tick();
        @(negedge clk);
        chk("t6_pending", 32'(occ1), 32'd3);
        set_lane(0, 0, 5'd5, 32'h45);
        set_lane(1, 0, 5'd6, 32'h46);
        resetn = 1'b0;
        tick();
        @(negedge clk);
        chk("t6_occ", 32'(occ1), 32'd0);
        chk("t6_we", 32'(rf_we1), 32'd0);
        chk("t6_ready", 32'(ready1), 32'd1);
        resetn = 1'b1;
        clear_lanes();
        tick();
        @(negedge clk);
        chk("t6_not_captured", 32'(occ1), 32'd0);

        // Randomised traffic with small register range for collisions and hits.
        for (int c = 0; c < 3000; c++) begin
            tick();
            resetn = ($urandom_range(0, 299) != 0);
            clear_lanes();
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 3) != 0)
                    set_lane(l, int'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom);
                in_regwrite[l] = ($urandom_range(0, 3) != 0);
            end
            q_raddr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
        end
        tick();
        clear_lanes();
        repeat (6) tick();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
